// File: rtl/dmem_bus_ctrl.sv
// dmem_bus_ctrl: bridges the single-cycle datapath's memory stage onto a
// wait-stated req/ack data bus. Each load/store is latched into request
// registers, held on the bus until ack (or timeout), and the core is stalled
// until the access completes.
module dmem_bus_ctrl #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic [3:0]  byteEnable,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        BusErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [29:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last BUSY cycle count before the access is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       access;

    // The two byte-offset address bits never reach the word-addressed bus.
    logic       unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, ALUResult[1:0]};

    assign access = MemRead | MemWrite;

    // Stall decode: hold the core while an access is pending or in flight,
    // release it in DONE so the datapath commits on that edge.
    always_comb begin
        // NOTE: default first so every path assigns Stall and no latch is inferred.
        Stall = 1'b0;
        case (state)
            IDLE:    Stall = access;
            BUSY:    Stall = 1'b1;
            DONE:    Stall = 1'b0;
            default: Stall = 1'b0;
        endcase
    end

    // Access FSM with registered bus outputs, timeout counter and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            ReadData  <= 32'd0;
            BusErr    <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= 30'd0;
            bus_wdata <= 32'd0;
            bus_be    <= 4'd0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (access) begin
                        // A simultaneous read+write request is issued as a write.
                        bus_req   <= 1'b1;
                        bus_we    <= MemWrite;
                        bus_addr  <= ALUResult[31:2];
                        bus_wdata <= WriteData;
                        bus_be    <= byteEnable;
                        cnt       <= 8'd0;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 8'd1;
                    if (bus_ack) begin
                        if (!bus_we) ReadData <= bus_rdata;
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        // Abandon the access; a timed-out write is simply dropped.
                        BusErr  <= 1'b1;
                        if (!bus_we) ReadData <= ERR_DATA;
                        bus_req <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    // Always pass through IDLE so the next instruction is evaluated fresh.
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
// tb_dmem_bus_ctrl: directed self-checking bench for dmem_bus_ctrl.
module tb_dmem_bus_ctrl;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [3:0]  byteEnable;
    logic [31:0] ReadData;
    logic        Stall;
    logic        BusErr;
    logic        bus_req;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int errors = 0;
    int checks = 0;
    int req_cycles;

    dmem_bus_ctrl #(.TIMEOUT(16), .ERR_DATA(32'hDEADBEEF)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .ALUResult  (ALUResult),
        .WriteData  (WriteData),
        .byteEnable (byteEnable),
        .ReadData   (ReadData),
        .Stall      (Stall),
        .BusErr     (BusErr),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_be     (bus_be),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        ALUResult = 32'd0; WriteData = 32'd0; byteEnable = 4'd0;
        bus_ack = 1'b0; bus_rdata = 32'd0;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_req",   {31'd0, bus_req}, 32'd0);
        chk("rst_rdata", ReadData, 32'd0);
        chk("rst_err",   {31'd0, BusErr}, 32'd0);
        chk("rst_stall", {31'd0, Stall}, 32'd0);
        chk("rst_addr",  {2'd0, bus_addr}, 32'd0);

        // Read, ack on the 3rd BUSY cycle.
        tick();
        MemRead = 1'b1; ALUResult = 32'h0000_0104;
        #1 chk("rd_stall_idle", {31'd0, Stall}, 32'd1);
        tick();
        chk("rd_req",   {31'd0, bus_req}, 32'd1);
        chk("rd_addr",  {2'd0, bus_addr}, 32'h41);
        chk("rd_we",    {31'd0, bus_we}, 32'd0);
        chk("rd_stall_b1", {31'd0, Stall}, 32'd1);
        tick();
        chk("rd_stall_b2", {31'd0, Stall}, 32'd1);
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
        #1 chk("rd_stall_b3", {31'd0, Stall}, 32'd1);
        tick();
        bus_ack = 1'b0;
        #1;
        chk("rd_stall_done", {31'd0, Stall}, 32'd0);
        chk("rd_data",       ReadData, 32'h1234_5678);
        chk("rd_req_done",   {31'd0, bus_req}, 32'd0);
        MemRead = 1'b0;

        // Byte write, 1-cycle ack; inputs wiggle while BUSY.
        tick();
        MemWrite = 1'b1; ALUResult = 32'h0000_0203;
        WriteData = 32'hAB00_0000; byteEnable = 4'b1000;
        #1 chk("wr_stall_idle", {31'd0, Stall}, 32'd1);
        tick();
        chk("wr_req",   {31'd0, bus_req}, 32'd1);
        chk("wr_we",    {31'd0, bus_we}, 32'd1);
        chk("wr_be",    {28'd0, bus_be}, 32'h8);
        chk("wr_wdata", bus_wdata, 32'hAB00_0000);
        chk("wr_addr",  {2'd0, bus_addr}, 32'h80);
        WriteData = 32'h1111_1111; ALUResult = 32'h0000_FFF0; byteEnable = 4'hF;
        bus_ack = 1'b1; bus_rdata = 32'hCAFE_F00D;
        #1;
        chk("wr_wdata_hold", bus_wdata, 32'hAB00_0000);
        chk("wr_addr_hold",  {2'd0, bus_addr}, 32'h80);
        tick();
        bus_ack = 1'b0;
        #1;
        chk("wr_rdata_keep", ReadData, 32'h1234_5678);
        chk("wr_req_done",   {31'd0, bus_req}, 32'd0);
        chk("wr_stall_done", {31'd0, Stall}, 32'd0);
        MemWrite = 1'b0;

        // Timeout read: no ack at all.
        tick();
        MemRead = 1'b1; ALUResult = 32'h0000_0010;
        tick();
        req_cycles = 0;
        while (bus_req && req_cycles < 40) begin
            req_cycles++;
            tick();
        end
        chk("to_req_cycles", 32'(req_cycles), 32'd16);
        chk("to_err",        {31'd0, BusErr}, 32'd1);
        chk("to_rdata",      ReadData, 32'hDEAD_BEEF);
        chk("to_stall_done", {31'd0, Stall}, 32'd0);
        MemRead = 1'b0;
        tick();
        chk("to_err_sticky", {31'd0, BusErr}, 32'd1);

        // Back-to-back: load acked in 1 cycle, access stays high into a store.
        MemRead = 1'b1; ALUResult = 32'h0000_0300;
        tick();
        bus_ack = 1'b1; bus_rdata = 32'h55AA_55AA;
        tick();
        bus_ack = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b1; ALUResult = 32'h0000_0404;
        WriteData = 32'h0BAD_F00D; byteEnable = 4'hF;
        #1;
        chk("b2b_stall_done", {31'd0, Stall}, 32'd0);
        chk("b2b_rdata",      ReadData, 32'h55AA_55AA);
        tick();
        chk("b2b_stall_idle", {31'd0, Stall}, 32'd1);
        chk("b2b_req_idle",   {31'd0, bus_req}, 32'd0);
        tick();
        chk("b2b_req",   {31'd0, bus_req}, 32'd1);
        chk("b2b_addr",  {2'd0, bus_addr}, 32'h101);
        chk("b2b_we",    {31'd0, bus_we}, 32'd1);
        chk("b2b_wdata", bus_wdata, 32'h0BAD_F00D);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0; MemWrite = 1'b0;
        #1 chk("b2b_rdata_keep", ReadData, 32'h55AA_55AA);
        tick();

        // Reset asserted on the 2nd BUSY cycle; later ack is ignored.
        MemRead = 1'b1; ALUResult = 32'h0000_0008;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mr_req",   {31'd0, bus_req}, 32'd0);
        chk("mr_stall", {31'd0, Stall}, 32'd1);
        chk("mr_err",   {31'd0, BusErr}, 32'd0);
        MemRead = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
        #1 chk("mr_stall_noacc", {31'd0, Stall}, 32'd0);
        tick();
        bus_ack = 1'b0;
        #1;
        chk("mr_late_req",   {31'd0, bus_req}, 32'd0);
        chk("mr_late_rdata", ReadData, 32'd0);

        // Stray idle ack, then MemRead=MemWrite=1 with byteEnable=0.
        bus_ack = 1'b1; bus_rdata = 32'h9999_9999;
        tick();
        bus_ack = 1'b0;
        #1;
        chk("idle_ack_req",   {31'd0, bus_req}, 32'd0);
        chk("idle_ack_rdata", ReadData, 32'd0);
        chk("idle_ack_stall", {31'd0, Stall}, 32'd0);
        MemRead = 1'b1; MemWrite = 1'b1; ALUResult = 32'h0000_0020;
        WriteData = 32'h0000_0077; byteEnable = 4'b0000;
        tick();
        chk("both_req",  {31'd0, bus_req}, 32'd1);
        chk("both_we",   {31'd0, bus_we}, 32'd1);
        chk("both_be",   {28'd0, bus_be}, 32'd0);
        chk("both_addr", {2'd0, bus_addr}, 32'h8);
        bus_ack = 1'b1; bus_rdata = 32'h4444_4444;
        tick();
        bus_ack = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        #1 chk("both_rdata_keep", ReadData, 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
